// File: rtl/types_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package : types_pkg
// Brief   : Shared widths, type encodings, FSM states and request/response
//           structs for the GEMM operand load sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package types_pkg;

    localparam int WORD_W       = 8;
    localparam int MAT_S_W      = 4;
    localparam int ROW_S_W      = 2;
    localparam int BITS_PER_ROW = 32;

    localparam int ROWS    = 2 ** ROW_S_W;
    localparam int NUM_REQ = 3 * ROWS;
    localparam int CNT_W   = ROW_S_W + 2;
    localparam int REQ_W   = WORD_W + MAT_S_W + ROW_S_W + 2;
    localparam int RSP_W   = BITS_PER_ROW + MAT_S_W + ROW_S_W + 2;

    localparam logic [1:0] TYPE_A = 2'b00;
    localparam logic [1:0] TYPE_B = 2'b01;
    localparam logic [1:0] TYPE_C = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]         typ;
        logic [MAT_S_W-1:0] mat;
        logic [ROW_S_W-1:0] row;
        logic [WORD_W-1:0]  word;
    } req_t;

    typedef struct packed {
        logic [1:0]              typ;
        logic [MAT_S_W-1:0]      mat;
        logic [ROW_S_W-1:0]      row;
        logic [BITS_PER_ROW-1:0] data;
    } rsp_t;

    // Counter layout is {type, row}: the top two bits walk A, B, C.
    function automatic logic [1:0] type_of(input logic [CNT_W-1:0] cnt);
        return cnt[CNT_W-1 -: 2];
    endfunction

    function automatic logic [ROW_S_W-1:0] row_of(input logic [CNT_W-1:0] cnt);
        return cnt[ROW_S_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_row_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : gemm_row_buf
// Brief  : One-entry valid/ready output register for the systolic row stream.
// Rev    : 1.0  initial release
// ============================================================================
module gemm_row_buf
    import types_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_pushValid,
    input  logic [BITS_PER_ROW-1:0] i_pushData,
    input  logic [1:0]              i_pushType,
    input  logic [ROW_S_W-1:0]      i_pushIdx,
    output logic                    o_space,
    output logic                    o_valid,
    output logic [BITS_PER_ROW-1:0] o_data,
    output logic [1:0]              o_type,
    output logic [ROW_S_W-1:0]      o_idx,
    input  logic                    i_ready
);

    logic                    r_valid;
    logic [BITS_PER_ROW-1:0] r_data;
    logic [1:0]              r_type;
    logic [ROW_S_W-1:0]      r_idx;

    // A new row may land in the same cycle the current one is consumed.
    assign o_space = !r_valid || i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_type  <= '0;
            r_idx   <= '0;
        end else if (i_pushValid) begin
            r_valid <= 1'b1;
            r_data  <= i_pushData;
            r_type  <= i_pushType;
            r_idx   <= i_pushIdx;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_type  = r_type;
    assign o_idx   = r_idx;

endmodule
`default_nettype wire

// File: rtl/gemm_load_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : gemm_load_sequencer
// Brief  : Issues scratchpad row reads for operands A, B, C and streams the
//          returned rows to the systolic array, checking response tags.
// Rev    : 1.0  initial release
// ============================================================================
module gemm_load_sequencer
    import types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [MAT_S_W-1:0]      mat_a,
    input  logic [MAT_S_W-1:0]      mat_b,
    input  logic [MAT_S_W-1:0]      mat_c,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rFIFO_WEN,
    output logic [REQ_W-1:0]        rFIFO_wdata,
    input  logic                    rFIFO_full,
    output logic                    gemmFIFO_REN,
    input  logic [RSP_W-1:0]        gemmFIFO_rdata,
    input  logic                    gemmFIFO_empty,
    output logic                    row_valid,
    output logic [BITS_PER_ROW-1:0] row_data,
    output logic [1:0]              row_type,
    output logic [ROW_S_W-1:0]      row_idx,
    input  logic                    row_ready
);

    localparam logic [CNT_W-1:0] c_NUM_REQ = CNT_W'(NUM_REQ);
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [MAT_S_W-1:0] r_matA;
    logic [MAT_S_W-1:0] r_matB;
    logic [MAT_S_W-1:0] r_matC;
    logic [CNT_W-1:0]   r_issueCnt;
    logic [CNT_W-1:0]   r_rcvCnt;
    logic               r_err;

    logic               w_startAcc;
    logic               w_wen;
    logic               w_ren;
    logic               w_space;
    logic               w_tagBad;
    logic [1:0]         w_reqType;
    logic [MAT_S_W-1:0] w_reqMat;
    logic [1:0]         w_expType;
    logic [MAT_S_W-1:0] w_expMat;
    req_t               w_req;
    rsp_t               w_rsp;

    assign w_startAcc = (r_state == IDLE) && start;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_reqType = type_of(r_issueCnt);
    assign w_expType = type_of(r_rcvCnt);

    always_comb begin
        w_reqMat = r_matC;
        w_expMat = r_matC;
        case (w_reqType)
            TYPE_A:  w_reqMat = r_matA;
            TYPE_B:  w_reqMat = r_matB;
            default: w_reqMat = r_matC;
        endcase
        case (w_expType)
            TYPE_A:  w_expMat = r_matA;
            TYPE_B:  w_expMat = r_matB;
            default: w_expMat = r_matC;
        endcase
    end

    always_comb begin
        w_req      = '0;
        w_req.typ  = w_reqType;
        w_req.mat  = w_reqMat;
        w_req.row  = row_of(r_issueCnt);
        w_req.word = '0;
    end

    assign w_wen       = (r_state == ISSUE) && !rFIFO_full && (r_issueCnt != c_NUM_REQ);
    assign rFIFO_WEN   = w_wen;
    assign rFIFO_wdata = (r_state == ISSUE) ? w_req : '0;

    // ------------------------------------------------------------------
    // Response side: pop only while a load is active, never from IDLE
    // ------------------------------------------------------------------
    assign w_rsp        = gemmFIFO_rdata;
    assign w_ren        = (r_state != IDLE) && !gemmFIFO_empty && w_space
                          && (r_rcvCnt < c_NUM_REQ);
    assign gemmFIFO_REN = w_ren;

    assign w_tagBad = w_ren &&
                      ({w_rsp.typ, w_rsp.mat, w_rsp.row} !=
                       {w_expType, w_expMat, row_of(r_rcvCnt)});

    gemm_row_buf u_rowBuf (
        .clk         (CLK),
        .rst         (RST),
        .i_pushValid (w_ren),
        .i_pushData  (w_rsp.data),
        .i_pushType  (w_rsp.typ),
        .i_pushIdx   (w_rsp.row),
        .o_space     (w_space),
        .o_valid     (row_valid),
        .o_data      (row_data),
        .o_type      (row_type),
        .o_idx       (row_idx),
        .i_ready     (row_ready)
    );

    // ------------------------------------------------------------------
    // Counters, operand IDs and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_matA     <= '0;
            r_matB     <= '0;
            r_matC     <= '0;
            r_issueCnt <= '0;
            r_rcvCnt   <= '0;
            r_err      <= 1'b0;
        end else if (w_startAcc) begin
            r_matA     <= mat_a;
            r_matB     <= mat_b;
            r_matC     <= mat_c;
            r_issueCnt <= '0;
            r_rcvCnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_wen) begin
                r_issueCnt <= r_issueCnt + 1'b1;
            end
            if (w_ren) begin
                r_rcvCnt <= r_rcvCnt + 1'b1;
            end
            if (w_tagBad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (w_wen && (r_issueCnt == c_LAST)) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((r_rcvCnt == c_NUM_REQ) && !row_valid) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gemm_load_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_gemm_load_sequencer
// Brief  : Scoreboard bench with an echoing scratchpad responder model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gemm_load_sequencer;
    import types_pkg::*;

    typedef struct packed {
        logic [1:0]              typ;
        logic [ROW_S_W-1:0]      idx;
        logic [BITS_PER_ROW-1:0] data;
    } row_t;

    logic                    CLK = 1'b0;
    logic                    RST = 1'b1;
    logic                    start = 1'b0;
    logic [MAT_S_W-1:0]      mat_a = '0;
    logic [MAT_S_W-1:0]      mat_b = '0;
    logic [MAT_S_W-1:0]      mat_c = '0;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    rFIFO_WEN;
    logic [REQ_W-1:0]        rFIFO_wdata;
    logic                    rFIFO_full = 1'b0;
    logic                    gemmFIFO_REN;
    logic [RSP_W-1:0]        gemmFIFO_rdata = '0;
    logic                    gemmFIFO_empty = 1'b1;
    logic                    row_valid;
    logic [BITS_PER_ROW-1:0] row_data;
    logic [1:0]              row_type;
    logic [ROW_S_W-1:0]      row_idx;
    logic                    row_ready = 1'b1;

    logic [REQ_W-1:0] expReqQ[$];
    row_t             expRowQ[$];
    logic [RSP_W-1:0] rspQ[$];
    int               wenCycQ[$];

    int nChecks = 0;
    int nPass   = 0;
    int cycle   = 0;
    int doneCnt = 0;
    int wenTotal = 0;
    int rowsOut = 0;
    int stallCycles = 0;
    int fullLeft = 0;
    int readyLeft = 0;
    int rspSeq = 0;
    int strayWant = 0, strayDone = 0;
    int flushWant = 0, flushDone = 0;
    bit stallArm = 0, stallCheck = 0;
    bit readyArm = 0, readyCheck = 0;
    bit corruptArm = 0, idleWatch = 0;
    bit prevFull = 0, heldValid = 0;
    logic [BITS_PER_ROW-1:0] heldData = '0;

    always #5 CLK = ~CLK;

    gemm_load_sequencer dut (
        .CLK            (CLK),
        .RST            (RST),
        .start          (start),
        .mat_a          (mat_a),
        .mat_b          (mat_b),
        .mat_c          (mat_c),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rFIFO_WEN      (rFIFO_WEN),
        .rFIFO_wdata    (rFIFO_wdata),
        .rFIFO_full     (rFIFO_full),
        .gemmFIFO_REN   (gemmFIFO_REN),
        .gemmFIFO_rdata (gemmFIFO_rdata),
        .gemmFIFO_empty (gemmFIFO_empty),
        .row_valid      (row_valid),
        .row_data       (row_data),
        .row_type       (row_type),
        .row_idx        (row_idx),
        .row_ready      (row_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input int t, input logic [MAT_S_W-1:0] m, input int r);
        req_t q;
        q.typ  = t[1:0];
        q.mat  = m;
        q.row  = r[ROW_S_W-1:0];
        q.word = '0;
        return q;
    endfunction

    // Monitor at negedge, responder/pacing updates just after posedge.
    initial begin : p_monitor
        bit               wenS, renS;
        logic [REQ_W-1:0] wdataS;
        logic [RSP_W-1:0] tmp;
        req_t             q;
        rsp_t             r;
        row_t             e;
        forever begin
            @(negedge CLK);
            cycle++;
            wenS = rFIFO_WEN;
            renS = gemmFIFO_REN;
            wdataS = rFIFO_wdata;
            if (!RST) begin
                if (stallCheck && rFIFO_full) begin
                    stallCycles++;
                    check_val("wen_in_stall", rFIFO_WEN, 0);
                    if (expReqQ.size() > 0) check_val("wdata_in_stall", rFIFO_wdata, expReqQ[0]);
                end
                if (stallCheck && prevFull && !rFIFO_full) check_val("wen_at_full_drop", rFIFO_WEN, 1);
                prevFull = rFIFO_full;
                if (readyCheck && !row_ready) begin
                    check_val("ren_ready_low", gemmFIFO_REN, 0);
                    check_val("valid_ready_low", row_valid, 1);
                    if (!heldValid) begin
                        heldValid = 1;
                        heldData  = row_data;
                    end else begin
                        check_val("data_held", row_data, heldData);
                    end
                end
                if (idleWatch) check_val("ren_idle", gemmFIFO_REN, 0);
                if (rFIFO_WEN) begin
                    wenTotal++;
                    wenCycQ.push_back(cycle);
                    if (expReqQ.size() == 0) check_val("req_extra", expReqQ.size(), 1);
                    else check_val("req_tag", rFIFO_wdata, expReqQ.pop_front());
                end
                if (row_valid && row_ready) begin
                    rowsOut++;
                    if (expRowQ.size() == 0) begin
                        check_val("row_extra", expRowQ.size(), 1);
                    end else begin
                        e = expRowQ.pop_front();
                        check_val("row", {row_type, row_idx, row_data}, e);
                    end
                end
                if (done) doneCnt++;
            end
            @(posedge CLK);
            #1;
            if (RST) begin
                expReqQ.delete();
                expRowQ.delete();
            end else begin
                if (renS && rspQ.size() > 0) tmp = rspQ.pop_front();
                if (wenS) begin
                    q     = wdataS;
                    r.typ = q.typ;
                    r.mat = q.mat;
                    r.row = q.row;
                    if (corruptArm && q.typ == TYPE_B && q.row == '0) begin
                        r.row      = ROW_S_W'(1);
                        corruptArm = 0;
                    end
                    r.data = {8'h5A, rspSeq[15:0], q.typ, q.mat, q.row};
                    rspSeq++;
                    rspQ.push_back(r);
                    e.typ  = r.typ;
                    e.idx  = r.row;
                    e.data = r.data;
                    expRowQ.push_back(e);
                end
                if (fullLeft > 0) begin
                    fullLeft--;
                    if (fullLeft == 0) rFIFO_full = 1'b0;
                end else if (stallArm && wenTotal == 3) begin
                    rFIFO_full = 1'b1;
                    fullLeft   = 5;
                    stallArm   = 0;
                end
                if (readyLeft > 0) begin
                    readyLeft--;
                    if (readyLeft == 0) row_ready = 1'b1;
                end else if (readyArm && rowsOut == 4) begin
                    row_ready = 1'b0;
                    readyLeft = 10;
                    readyArm  = 0;
                end
            end
            if (strayDone < strayWant) begin
                rspQ.push_back({TYPE_A, 4'h9, 2'd0, 32'hDEAD_BEEF});
                strayDone++;
            end
            if (flushDone < flushWant) begin
                rspQ.delete();
                flushDone++;
            end
            gemmFIFO_empty = (rspQ.size() == 0);
            gemmFIFO_rdata = (rspQ.size() == 0) ? '0 : rspQ[0];
        end
    end

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (doneCnt == base && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (doneCnt == base) check_val("done_timeout", doneCnt - base, 1);
    endtask

    task automatic push_expected(input logic [MAT_S_W-1:0] a, input logic [MAT_S_W-1:0] b,
                                 input logic [MAT_S_W-1:0] c);
        logic [MAT_S_W-1:0] m;
        for (int t = 0; t < 3; t++) begin
            m = (t == 0) ? a : (t == 1) ? b : c;
            for (int rr = 0; rr < ROWS; rr++) expReqQ.push_back(mk_req(t, m, rr));
        end
    endtask

    task automatic do_load(input logic [MAT_S_W-1:0] a, input logic [MAT_S_W-1:0] b,
                           input logic [MAT_S_W-1:0] c, input bit extraStart);
        int base;
        @(posedge CLK);
        #1;
        mat_a = a; mat_b = b; mat_c = c;
        wenTotal = 0;
        rowsOut  = 0;
        wenCycQ.delete();
        base = doneCnt;
        push_expected(a, b, c);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(negedge CLK);
        check_val("busy_after_start", busy, 1);
        check_val("err_cleared", err, 0);
        if (extraStart) begin
            repeat (2) @(posedge CLK);
            #1;
            mat_a = 4'h7; mat_b = 4'h7; mat_c = 4'h7;
            start = 1'b1;
            @(posedge CLK);
            #1;
            start = 1'b0;
        end
        wait_done(base, 300);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check_val("done_once", doneCnt - base, 1);
        check_val("req_count", wenTotal, NUM_REQ);
        check_val("rows_out", rowsOut, NUM_REQ);
        check_val("busy_idle", busy, 0);
        check_val("exp_req_left", expReqQ.size(), 0);
        check_val("exp_row_left", expRowQ.size(), 0);
    endtask

    initial begin : p_main
        int base;
        int n;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("reset_outputs", {busy, done, err, rFIFO_WEN, rFIFO_wdata, gemmFIFO_REN,
                                    row_valid, row_data, row_type, row_idx}, '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Plain load, echoing responder.
        do_load(4'd1, 4'd2, 4'd3, 0);
        check_val("err_clean", err, 0);
        check_val("wen_span", (wenCycQ.size() > 0) ? wenCycQ[$] - wenCycQ[0] : -1, NUM_REQ - 1);

        // Request FIFO full after the third request.
        stallCycles = 0;
        stallArm    = 1;
        stallCheck  = 1;
        do_load(4'd1, 4'd2, 4'd3, 0);
        stallCheck  = 0;
        check_val("stall_cycles", stallCycles, 5);
        check_val("wen_span_stall", (wenCycQ.size() > 0) ? wenCycQ[$] - wenCycQ[0] : -1, NUM_REQ - 1 + 5);

        // Row consumer back-pressure mid-stream.
        heldValid  = 0;
        readyArm   = 1;
        readyCheck = 1;
        do_load(4'd4, 4'd5, 4'd6, 0);
        readyCheck = 0;
        check_val("ready_restored", row_ready, 1);

        // Tag mismatch: B2r1 returned where B2r0 is expected.
        corruptArm = 1;
        do_load(4'd1, 4'd2, 4'd3, 0);
        check_val("err_sticky", err, 1);

        // Second start while busy is ignored; the accepted start clears err.
        do_load(4'd2, 4'd3, 4'd1, 1);
        check_val("err_after_clean", err, 0);

        // Reset in the middle of a load.
        @(posedge CLK);
        #1;
        mat_a = 4'd1; mat_b = 4'd2; mat_c = 4'd3;
        wenTotal = 0;
        base = doneCnt;
        push_expected(4'd1, 4'd2, 4'd3);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        n = 0;
        while (wenTotal < 6 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_val("six_reqs_seen", wenTotal >= 6, 1);
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            check_val("reset_mid_outputs", {busy, done, err, rFIFO_WEN, rFIFO_wdata, gemmFIFO_REN,
                                            row_valid, row_data, row_type, row_idx}, '0);
        end
        flushWant++;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("no_done_abort", doneCnt - base, 0);

        // Response sitting in the FIFO while idle must stay there.
        strayWant++;
        repeat (2) @(posedge CLK);
        idleWatch = 1;
        repeat (5) @(negedge CLK);
        idleWatch = 0;
        check_val("stray_kept", rspQ.size(), 1);
        flushWant++;
        repeat (2) @(posedge CLK);

        do_load(4'd1, 4'd2, 4'd3, 0);
        check_val("err_after_reset_load", err, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
        $fatal(1);
    end

endmodule
`default_nettype wire
